// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - register map, bit indices and FSM states for spi_target
package spi_target_pkg;

    // Byte offsets within the 16-byte register window.
    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_RXDATA = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    // STATUS bit positions.
    localparam int STAT_RX_VALID  = 0;
    localparam int STAT_TX_EMPTY  = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_CS_ACTIVE = 3;

    // CTRL bit positions.
    localparam int CTRL_EN   = 0;
    localparam int CTRL_RXIE = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_target_sync_2ff.sv
// rtl/spi_target_sync_2ff.sv - two-flop synchroniser with selectable reset value
// Ports: clk, rst_n (async, active-low), d (asynchronous input), q (synchronised output).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target with memory-mapped TX/RX byte registers
// Ports: clk, rst_n (async, active-low); mem_addr/mem_wdata/mem_we/mem_re/mem_rdata core bus;
//        ena (CTRL.EN for pin mux); spi_sclk_in/spi_cs_n_in/spi_mosi_in asynchronous pins;
//        spi_miso_out/spi_miso_oe MISO drive; irq (RXIE & rx_valid).
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [31:0] SPI_TARGET_BASE_ADDR = 32'h40006000,
    parameter logic [7:0]  IDLE_FILL            = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        ena,
    input  logic        spi_sclk_in,
    input  logic        spi_cs_n_in,
    input  logic        spi_mosi_in,
    output logic        spi_miso_out,
    output logic        spi_miso_oe,
    output logic        irq
);

    localparam logic [27:0] BASE_HI = SPI_TARGET_BASE_ADDR[31:4];

    logic       sclk_s, cs_n_s, mosi_s;
    logic       sclk_d, cs_n_d;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
    state_t     state, state_nxt;
    logic       enter, run, byte_done, tx_load;
    logic [7:0] tx_shift, tx_hold;
    logic       tx_full;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic [2:0] bit_cnt;
    logic       load_pend;
    logic [7:0] rx_data;
    logic       rx_valid, overrun;
    logic       ctrl_en, ctrl_rxie;
    logic       in_block;
    logic [3:0] offset;
    logic       rd_rx, wr_tx, wr_status, wr_ctrl;
    logic [3:0] status;
    logic       unused_wdata;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi_sclk_in), .q(sclk_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst_n(rst_n), .d(spi_cs_n_in), .q(cs_n_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi_in), .q(mosi_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            cs_n_d <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_n_d <= cs_n_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_n_s & cs_n_d;
    assign cs_rise   = cs_n_s & ~cs_n_d;

    // Bus decode
    assign in_block     = (mem_addr[31:4] == BASE_HI);
    assign offset       = mem_addr[3:0];
    assign rd_rx        = mem_re && in_block && (offset == OFF_RXDATA);
    assign wr_tx        = mem_we && in_block && (offset == OFF_TXDATA);
    assign wr_status    = mem_we && in_block && (offset == OFF_STATUS);
    assign wr_ctrl      = mem_we && in_block && (offset == OFF_CTRL);
    assign unused_wdata = ^mem_wdata[31:8];

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (ctrl_en && cs_fall) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (!ctrl_en || cs_rise) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // 'run' excludes the cycle that leaves ACTIVE, so a cs_n rise coinciding
    // with an sclk edge discards the edge rather than completing a byte.
    assign enter     = (state == ST_IDLE) && (state_nxt == ST_ACTIVE);
    assign run       = (state == ST_ACTIVE) && (state_nxt == ST_ACTIVE);
    assign byte_done = run && sclk_rise && (bit_cnt == 3'd7);
    assign tx_load   = enter || (run && sclk_fall && load_pend);
    assign rx_byte   = {rx_shift, mosi_s};

    // TX path: a same-cycle bus write lands in the holding register after
    // the load has taken the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= 8'h00;
            tx_hold  <= 8'h00;
            tx_full  <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_shift <= tx_full ? tx_hold : IDLE_FILL;
            end else if (run && sclk_fall) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (wr_tx) begin
                tx_hold <= mem_wdata[7:0];
                tx_full <= 1'b1;
            end else if (tx_load) begin
                tx_full <= 1'b0;
            end
        end
    end

    // RX shifter and bit counter; cleared whenever not running so an aborted
    // byte leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift  <= 7'h00;
            bit_cnt   <= 3'd0;
            load_pend <= 1'b0;
        end else if (run) begin
            if (sclk_rise) begin
                rx_shift <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    load_pend <= 1'b1;
                end
            end else if (sclk_fall) begin
                load_pend <= 1'b0;
            end
        end else begin
            rx_shift  <= 7'h00;
            bit_cnt   <= 3'd0;
            load_pend <= 1'b0;
        end
    end

    // RXDATA / flags. A read in the same cycle as a completing byte counts as
    // having emptied the register first, so the new byte is accepted cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            ctrl_en   <= 1'b0;
            ctrl_rxie <= 1'b0;
        end else begin
            if (byte_done && (!rx_valid || rd_rx)) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (byte_done && rx_valid && !rd_rx) begin
                overrun <= 1'b1;
            end else if (wr_status && mem_wdata[STAT_OVERRUN]) begin
                overrun <= 1'b0;
            end
            if (wr_ctrl) begin
                ctrl_en   <= mem_wdata[CTRL_EN];
                ctrl_rxie <= mem_wdata[CTRL_RXIE];
            end
        end
    end

    always_comb begin
        status                 = 4'h0;
        status[STAT_RX_VALID]  = rx_valid;
        status[STAT_TX_EMPTY]  = ~tx_full;
        status[STAT_OVERRUN]   = overrun;
        status[STAT_CS_ACTIVE] = (state == ST_ACTIVE);
    end

    // Gated by rst_n so the bus reads 0 while reset is held, even though
    // tx_empty itself resets to 1.
    always_comb begin
        mem_rdata = 32'h0;
        if (rst_n && mem_re && in_block) begin
            case (offset)
                OFF_RXDATA: mem_rdata = {24'h0, rx_data};
                OFF_STATUS: mem_rdata = {28'h0, status};
                OFF_CTRL:   mem_rdata = {30'h0, ctrl_rxie, ctrl_en};
                default:    mem_rdata = 32'h0;
            endcase
        end
    end

    assign ena          = ctrl_en;
    assign spi_miso_out = tx_shift[7];
    assign spi_miso_oe  = (state == ST_ACTIVE);
    assign irq          = ctrl_rxie & rx_valid;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - self-checking bench for spi_target
module tb_spi_target;
    import spi_target_pkg::*;

    localparam logic [31:0] BASE = 32'h40006000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic        ena, irq;
    logic        spi_sclk_in, spi_cs_n_in, spi_mosi_in;
    logic        spi_miso_out, spi_miso_oe;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] collide_data;

    // Reference model state
    logic [7:0] m_rx_data, m_tx_val;
    logic       m_rx_valid, m_overrun, m_tx_full, m_en, m_rxie;

    spi_target #(.SPI_TARGET_BASE_ADDR(BASE), .IDLE_FILL(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .ena(ena),
        .spi_sclk_in(spi_sclk_in), .spi_cs_n_in(spi_cs_n_in), .spi_mosi_in(spi_mosi_in),
        .spi_miso_out(spi_miso_out), .spi_miso_oe(spi_miso_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void m_reset();
        m_rx_data = 8'h00; m_tx_val = 8'h00;
        m_rx_valid = 1'b0; m_overrun = 1'b0; m_tx_full = 1'b0; m_en = 1'b0; m_rxie = 1'b0;
    endfunction

    // Byte the target will shift out next; taking it empties the holding register.
    function automatic logic [7:0] m_load();
        logic [7:0] v;
        v = m_tx_full ? m_tx_val : 8'hFF;
        m_tx_full = 1'b0;
        return v;
    endfunction

    function automatic void m_byte(input logic [7:0] b, input bit read_same);
        if (!m_rx_valid || read_same) begin
            m_rx_data = b;
            m_rx_valid = 1'b1;
        end else begin
            m_overrun = 1'b1;
        end
    endfunction

    function automatic logic [31:0] m_status(input logic active);
        return {28'h0, active, m_overrun, ~m_tx_full, m_rx_valid};
    endfunction

    task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
        @(negedge clk);
        mem_addr = BASE + {24'h0, off}; mem_wdata = d; mem_we = 1'b1;
        @(negedge clk);
        mem_we = 1'b0;
        case (off)
            8'h00: begin m_tx_full = 1'b1; m_tx_val = d[7:0]; end
            8'h08: if (d[2]) m_overrun = 1'b0;
            8'h0C: begin m_en = d[0]; m_rxie = d[1]; end
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [7:0] off, output logic [31:0] d);
        @(negedge clk);
        mem_addr = BASE + {24'h0, off}; mem_re = 1'b1;
        #1 d = mem_rdata;
        @(negedge clk);
        mem_re = 1'b0;
        if (off == 8'h04) m_rx_valid = 1'b0;
    endtask

    task automatic cs_begin();
        spi_cs_n_in = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clk);
        spi_cs_n_in = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // One mode-0 bit at sclk = clk/8. MISO is sampled just before the rising
    // edge, as a controller would. With 'collide', RXDATA is read in the exact
    // cycle the target registers the rise.
    task automatic spi_bit(input logic mo, input bit collide, output logic mi, output logic oe);
        spi_mosi_in = mo;
        repeat (4) @(negedge clk);
        mi = spi_miso_out;
        oe = spi_miso_oe;
        spi_sclk_in = 1'b1;
        if (collide) begin
            repeat (2) @(negedge clk);
            mem_addr = BASE + 32'h4; mem_re = 1'b1;
            #1 collide_data = mem_rdata;
            @(negedge clk);
            mem_re = 1'b0;
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        spi_sclk_in = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] mo, input int nbits, input int wr_at,
                            input logic [7:0] wr_val, input bit collide,
                            output logic [7:0] mi, output int oe_cnt);
        logic b, o;
        mi = 8'h00;
        oe_cnt = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i == wr_at) bus_write(8'h00, {24'h0, wr_val});
            spi_bit(mo[7-i], collide && (i == 7), b, o);
            mi = {mi[6:0], b};
            if (o) oe_cnt++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        mem_addr = BASE + 32'h8; mem_re = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", mem_rdata); end
        n_checks++; if ({ena, spi_miso_out, spi_miso_oe, irq} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_outputs: got %b want 0000", {ena, spi_miso_out, spi_miso_oe, irq}); end
        rst_n = 1'b1; mem_re = 1'b0;
        m_reset();
        #1;
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_no_re: got %h want 0", mem_rdata); end
        bus_read(8'h08, d);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h want 2", d); end
        bus_read(8'h0C, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", d); end
        bus_read(8'h04, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_rxdata: got %h want 0", d); end
        bus_read(8'h00, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", d); end
        bus_read(8'h14, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL outside_read: got %h want 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [7:0] exp, mi;
        int oe;
        bus_write(8'h0C, 32'h3);
        bus_write(8'h00, 32'hA5);
        cs_begin();
        exp = m_load();
        bus_read(8'h08, d);
        n_checks++; if (d !== m_status(1'b1)) begin n_fail++; $display("FAIL basic_status_active: got %h want %h", d, m_status(1'b1)); end
        spi_byte(8'h3C, 8, -1, 8'h00, 1'b0, mi, oe);
        m_byte(8'h3C, 1'b0);
        void'(m_load());
        cs_end();
        n_checks++; if (mi !== exp) begin n_fail++; $display("FAIL basic_miso: got %h want %h", mi, exp); end
        n_checks++; if (oe !== 8) begin n_fail++; $display("FAIL basic_oe: got %0d want 8", oe); end
        n_checks++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL basic_oe_idle: got %b want 0", spi_miso_oe); end
        n_checks++; if (irq !== (m_rxie & m_rx_valid)) begin n_fail++; $display("FAIL basic_irq: got %b want %b", irq, m_rxie & m_rx_valid); end
        n_checks++; if (ena !== m_en) begin n_fail++; $display("FAIL basic_ena: got %b want %b", ena, m_en); end
        bus_read(8'h08, d);
        n_checks++; if (d !== m_status(1'b0)) begin n_fail++; $display("FAIL basic_status: got %h want %h", d, m_status(1'b0)); end
        exp = m_rx_data;
        bus_read(8'h04, d);
        n_checks++; if (d !== {24'h0, exp}) begin n_fail++; $display("FAIL basic_rxdata: got %h want %h", d, exp); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_cleared: got %b want 0", irq); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [7:0] exp0, exp1, mi0, mi1, er;
        int oe;
        cs_begin();
        exp0 = m_load();
        spi_byte(8'h11, 8, -1, 8'h00, 1'b0, mi0, oe);
        m_byte(8'h11, 1'b0);
        exp1 = m_load();
        spi_byte(8'h22, 8, -1, 8'h00, 1'b0, mi1, oe);
        m_byte(8'h22, 1'b0);
        void'(m_load());
        cs_end();
        n_checks++; if ({mi0, mi1} !== {exp0, exp1}) begin n_fail++; $display("FAIL ovr_miso: got %h want %h", {mi0, mi1}, {exp0, exp1}); end
        bus_read(8'h08, d);
        n_checks++; if (d !== m_status(1'b0)) begin n_fail++; $display("FAIL ovr_status: got %h want %h", d, m_status(1'b0)); end
        bus_write(8'h08, 32'h4);
        bus_read(8'h08, d);
        n_checks++; if (d !== m_status(1'b0)) begin n_fail++; $display("FAIL ovr_w1c: got %h want %h", d, m_status(1'b0)); end
        er = m_rx_data;
        bus_read(8'h04, d);
        n_checks++; if (d !== {24'h0, er}) begin n_fail++; $display("FAIL ovr_rxdata: got %h want %h", d, er); end
    endtask

    task automatic test_idle_fill();
        logic [31:0] d;
        logic [7:0] exp0, exp1, mi0, mi1;
        int oe;
        cs_begin();
        exp0 = m_load();
        spi_byte(8'($urandom), 8, 3, 8'h5A, 1'b0, mi0, oe);
        m_byte(8'h00, 1'b0);
        exp1 = m_load();
        spi_byte(8'($urandom), 8, -1, 8'h00, 1'b0, mi1, oe);
        void'(m_load());
        cs_end();
        n_checks++; if (mi0 !== exp0) begin n_fail++; $display("FAIL fill_byte0: got %h want %h", mi0, exp0); end
        n_checks++; if (mi1 !== exp1) begin n_fail++; $display("FAIL fill_byte1: got %h want %h", mi1, exp1); end
        bus_read(8'h04, d);
        bus_write(8'h08, 32'h4);
        m_overrun = 1'b0;
        m_rx_valid = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic [7:0] exp, mi;
        int oe;
        cs_begin();
        void'(m_load());
        spi_byte(8'hF0, 5, -1, 8'h00, 1'b0, mi, oe);
        cs_end();
        n_checks++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL abort_oe: got %b want 0", spi_miso_oe); end
        bus_read(8'h08, d);
        n_checks++; if (d !== m_status(1'b0)) begin n_fail++; $display("FAIL abort_status: got %h want %h", d, m_status(1'b0)); end
        cs_begin();
        exp = m_load();
        spi_byte(8'h81, 8, -1, 8'h00, 1'b0, mi, oe);
        m_byte(8'h81, 1'b0);
        void'(m_load());
        cs_end();
        n_checks++; if (mi !== exp) begin n_fail++; $display("FAIL abort_next_miso: got %h want %h", mi, exp); end
        bus_read(8'h04, d);
        n_checks++; if (d !== {24'h0, m_rx_data}) begin n_fail++; $display("FAIL abort_next_rx: got %h want %h", d, m_rx_data); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic [7:0] a, b, mi, old;
        int oe;
        a = 8'($urandom);
        b = ~a;
        cs_begin();
        void'(m_load());
        spi_byte(a, 8, -1, 8'h00, 1'b0, mi, oe);
        m_byte(a, 1'b0);
        void'(m_load());
        cs_end();
        old = m_rx_data;
        cs_begin();
        void'(m_load());
        spi_byte(b, 8, -1, 8'h00, 1'b1, mi, oe);
        m_byte(b, 1'b1);
        void'(m_load());
        cs_end();
        n_checks++; if (collide_data !== {24'h0, old}) begin n_fail++; $display("FAIL coll_read: got %h want %h", collide_data, old); end
        bus_read(8'h08, d);
        n_checks++; if (d !== m_status(1'b0)) begin n_fail++; $display("FAIL coll_status: got %h want %h", d, m_status(1'b0)); end
        bus_read(8'h04, d);
        n_checks++; if (d !== {24'h0, b}) begin n_fail++; $display("FAIL coll_rxdata: got %h want %h", d, b); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [7:0] mo, mi, exp, wv, er;
        int nb, wa, oe;
        for (int f = 0; f < 6; f++) begin
            bus_write(8'h0C, {30'h0, 1'($urandom_range(0, 1)), 1'b1});
            nb = $urandom_range(1, 3);
            cs_begin();
            exp = m_load();
            for (int k = 0; k < nb; k++) begin
                mo = 8'($urandom);
                wa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 7)) : -1;
                wv = 8'($urandom);
                spi_byte(mo, 8, wa, wv, 1'b0, mi, oe);
                n_checks++; if (mi !== exp) begin n_fail++; $display("FAIL rand_miso f%0d b%0d: got %h want %h", f, k, mi, exp); end
                m_byte(mo, 1'b0);
                exp = m_load();
                if ($urandom_range(0, 2) == 0) begin
                    er = m_rx_data;
                    bus_read(8'h04, d);
                    n_checks++; if (d !== {24'h0, er}) begin n_fail++; $display("FAIL rand_rx f%0d b%0d: got %h want %h", f, k, d, er); end
                end
            end
            cs_end();
            if ($urandom_range(0, 1) != 0) bus_write(8'h08, 32'h4);
            n_checks++; if (irq !== (m_rxie & m_rx_valid)) begin n_fail++; $display("FAIL rand_irq f%0d: got %b want %b", f, irq, m_rxie & m_rx_valid); end
            bus_read(8'h08, d);
            n_checks++; if (d !== m_status(1'b0)) begin n_fail++; $display("FAIL rand_status f%0d: got %h want %h", f, d, m_status(1'b0)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [7:0] exp, mi;
        int oe;
        bus_write(8'h0C, 32'h3);
        cs_begin();
        void'(m_load());
        spi_byte(8'hC3, 8, -1, 8'h00, 1'b0, mi, oe);
        m_byte(8'hC3, 1'b0);
        void'(m_load());
        cs_end();
        bus_write(8'h00, 32'h77);
        cs_begin();
        spi_byte(8'hE7, 3, -1, 8'h00, 1'b0, mi, oe);
        @(negedge clk);
        rst_n = 1'b0;
        mem_addr = BASE + 32'h8; mem_re = 1'b1;
        #1;
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_rdata: got %h want 0", mem_rdata); end
        n_checks++; if ({ena, spi_miso_out, spi_miso_oe, irq} !== 4'b0000) begin n_fail++;
            $display("FAIL rmid_outputs: got %b want 0000", {ena, spi_miso_out, spi_miso_oe, irq}); end
        spi_cs_n_in = 1'b1; spi_sclk_in = 1'b0; spi_mosi_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; mem_re = 1'b0;
        m_reset();
        bus_read(8'h08, d);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL rmid_status: got %h want 2", d); end
        bus_read(8'h0C, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rmid_ctrl: got %h want 0", d); end
        bus_read(8'h04, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rmid_rxdata: got %h want 0", d); end
        cs_begin();
        spi_byte(8'h5A, 8, -1, 8'h00, 1'b0, mi, oe);
        cs_end();
        n_checks++; if (oe !== 0) begin n_fail++; $display("FAIL dis_oe: got %0d want 0", oe); end
        bus_read(8'h08, d);
        n_checks++; if (d !== m_status(1'b0)) begin n_fail++; $display("FAIL dis_status: got %h want %h", d, m_status(1'b0)); end
        bus_write(8'h0C, 32'h1);
        cs_begin();
        exp = m_load();
        spi_byte(8'h96, 8, -1, 8'h00, 1'b0, mi, oe);
        m_byte(8'h96, 1'b0);
        void'(m_load());
        cs_end();
        n_checks++; if (mi !== exp) begin n_fail++; $display("FAIL post_miso: got %h want %h", mi, exp); end
        bus_read(8'h04, d);
        n_checks++; if (d !== {24'h0, m_rx_data}) begin n_fail++; $display("FAIL post_rx: got %h want %h", d, m_rx_data); end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_we = 1'b0; mem_re = 1'b0;
        spi_sclk_in = 1'b0; spi_cs_n_in = 1'b1; spi_mosi_in = 1'b0;
        collide_data = 32'h0;
        m_reset();
        test_reset();
        test_basic();
        test_overrun();
        test_idle_fill();
        test_abort();
        test_collision();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
